// File: rtl/sa1_mem_pkg.sv
// rtl/sa1_mem_pkg.sv - shared state, requester index and counter definitions for the ROM arbiter
package sa1_mem_pkg;

    localparam int CNT_W    = 4;
    localparam int IDX_SNES = 0;
    localparam int IDX_SA1  = 1;
    localparam int IDX_MCU  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    // A zero-length strobe would never complete, so it is stretched to one cycle.
    function automatic logic [CNT_W-1:0] strobe_len(input int cyc);
        if (cyc < 1) begin
            return CNT_W'(1);
        end
        return CNT_W'(cyc);
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// rtl/rom_arb_pick.sv - combinational grant selector: SNES fixed priority, SA-1/MCU round-robin
module rom_arb_pick
    import sa1_mem_pkg::*;
(
    input  logic [2:0] req,
    input  logic       ptr,
    input  logic       mcu_en,
    output logic [2:0] grant,
    output logic       valid
);

    logic [2:0] req_m;

    assign req_m = {req[IDX_MCU] & mcu_en, req[IDX_SA1], req[IDX_SNES]};
    assign valid = |req_m;

    // ptr=0 favours SA-1 on a tie, ptr=1 favours the MCU.
    always_comb begin
        grant = 3'b000;
        if (req_m[IDX_SNES]) begin
            grant[IDX_SNES] = 1'b1;
        end else if (req_m[IDX_SA1] && req_m[IDX_MCU]) begin
            if (ptr) begin
                grant[IDX_MCU] = 1'b1;
            end else begin
                grant[IDX_SA1] = 1'b1;
            end
        end else if (req_m[IDX_SA1]) begin
            grant[IDX_SA1] = 1'b1;
        end else if (req_m[IDX_MCU]) begin
            grant[IDX_MCU] = 1'b1;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - three-requester SRAM0 arbiter with fixed-length strobes
// ROM_ARBITER_MCU_EN enables the MCU requester (bit 2); otherwise it is ignored.
module rom_arbiter
    import sa1_mem_pkg::*;
#(
    parameter int RD_CYC = 4,
    parameter int WR_CYC = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  REQ,
    input  logic [2:0]  REQ_WE,
    input  logic [71:0] REQ_ADDR,
    input  logic [23:0] REQ_WDATA,
    output logic [2:0]  RDY,
    output logic [7:0]  RDATA,
    output logic [23:0] MEM_ADDR,
    output logic [7:0]  MEM_DOUT,
    input  logic [7:0]  MEM_DIN,
    output logic        MEM_OE_N,
    output logic        MEM_WE_N,
    output logic        BUSY
);

`ifdef ROM_ARBITER_MCU_EN
    localparam logic MCU_EN = 1'b1;
`else
    localparam logic MCU_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] RD_N = strobe_len(RD_CYC);
    localparam logic [CNT_W-1:0] WR_N = strobe_len(WR_CYC);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt_idx;
    logic             gnt_we;
    logic             rr_ptr;
    logic [2:0]       pick_grant;
    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic             strobe_end;
    logic             take;

    rom_arb_pick u_pick (
        .req    (REQ),
        .ptr    (rr_ptr),
        .mcu_en (MCU_EN),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = 2'd0;
        if (pick_grant[IDX_MCU]) begin
            pick_idx = 2'd2;
        end else if (pick_grant[IDX_SA1]) begin
            pick_idx = 2'd1;
        end
    end

    assign strobe_end = (cnt == (gnt_we ? WR_N : RD_N));
    assign take       = (state == ST_IDLE) && pick_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        MEM_OE_N   = 1'b1;
        MEM_WE_N   = 1'b1;
        RDY        = 3'b000;
        BUSY       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (gnt_we) begin
                    MEM_WE_N = 1'b0;
                end else begin
                    MEM_OE_N = 1'b0;
                end
                if (strobe_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                RDY        = (3'b001 << gnt_idx) & {MCU_EN, 2'b11};
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The pointer moves to the loser of each SA-1/MCU grant; SNES grants leave it alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MEM_ADDR <= 24'h000000;
            MEM_DOUT <= 8'h00;
            RDATA    <= 8'h00;
            cnt      <= '0;
            gnt_idx  <= 2'd0;
            gnt_we   <= 1'b0;
            rr_ptr   <= 1'b0;
        end else begin
            if (take) begin
                MEM_ADDR <= REQ_ADDR[int'(pick_idx)*24 +: 24];
                MEM_DOUT <= REQ_WDATA[int'(pick_idx)*8 +: 8];
                gnt_idx  <= pick_idx;
                gnt_we   <= REQ_WE[pick_idx];
                cnt      <= CNT_W'(1);
                if (!pick_grant[IDX_SNES]) begin
                    rr_ptr <= pick_grant[IDX_SA1];
                end
            end else if (state == ST_STROBE) begin
                if (strobe_end) begin
                    if (!gnt_we) begin
                        RDATA <= MEM_DIN;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
